// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin mux stage.
package rr_mux_pkg;

  localparam int unsigned N_SRC = 4;

  // Source index: rotation pointer, grant and out_sel.
  typedef logic [1:0] src_idx_t;

endpackage

// File: rtl/rr_mux_4_stage_if.sv
// Source/sink handshake bundle for rr_mux_4_stage.
interface rr_mux_4_stage_if
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) ();

  logic [N_SRC-1:0] in_valid;
  logic [N_SRC-1:0] in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  src_idx_t         out_sel;

  // Mux stage side.
  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // Sources plus consumer side.
  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: first requester at or after ptr, mod 4.
module rr_pick_4
  import rr_mux_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  output logic             any,
  output src_idx_t         g
);

  logic [2*N_SRC-1:0] dbl;
  logic [2*N_SRC-1:0] dbl_sh;
  logic [N_SRC-1:0]   rot;
  src_idx_t           off;

  // Rotate so ptr lands on bit 0, fixed-priority pick, then add ptr back.
  always_comb begin
    dbl    = {req, req};
    dbl_sh = dbl >> ptr;
    rot    = dbl_sh[N_SRC-1:0];
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    else             off = 2'd0;
    any = |req;
    g   = off + ptr;
  end

endmodule

// File: rtl/rr_mux_4_stage.sv
// Registered 4-input round-robin arbitrating multiplexer stage.
module rr_mux_4_stage
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  rr_mux_4_stage_if.slave  bus
);

  logic             load_en;
  logic             any;
  src_idx_t         g;
  src_idx_t         ptr;
  logic [N_SRC-1:0] sel_oh;
  logic [WIDTH-1:0] mux_data;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  src_idx_t         out_sel_q;

  rr_pick_4 u_pick (
    .req (bus.in_valid),
    .ptr (ptr),
    .any (any),
    .g   (g)
  );

  // Slot free/draining, one-hot grant decode, and-or data select, accept strobes.
  always_comb begin
    load_en = ~out_valid_q | bus.out_ready;
    sel_oh  = '0;
    if (any) sel_oh[g] = 1'b1;
    mux_data = ({WIDTH{sel_oh[0]}} & bus.d0)
             | ({WIDTH{sel_oh[1]}} & bus.d1)
             | ({WIDTH{sel_oh[2]}} & bus.d2)
             | ({WIDTH{sel_oh[3]}} & bus.d3);
    bus.in_ready = (load_en & ~rst) ? sel_oh : '0;
  end

  // Output register and rotation pointer; data/sel hold when the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr         <= '0;
    end else if (load_en) begin
      if (any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_data;
        out_sel_q   <= g;
        ptr         <= g + 2'd1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_4_stage.sv
// Scoreboard bench for rr_mux_4_stage: directed plan vectors then random traffic.
module tb_rr_mux_4_stage;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } item_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  item_t q[$];
  int    pushed_now;

  // Reference state: priority pointer, slot occupancy, previous-cycle reset.
  int m_ptr;
  int m_occ;
  int m_prev_rst;

  rr_mux_4_stage_if #(.WIDTH(W)) bus ();

  rr_mux_4_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic [3:0] v,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic ordy);
    logic [W-1:0] dv [4];
    logic [3:0]   exp_ready;
    int           gi;
    item_t        it;
    @(posedge clk);
    #1;
    rst = r;
    bus.in_valid = v;
    bus.d0 = a; bus.d1 = b; bus.d2 = c; bus.d3 = d;
    bus.out_ready = ordy;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    #3;
    pushed_now = 0;
    exp_ready  = 4'b0000;
    if (r) begin
      if (m_prev_rst != 0) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sel !== 2'd0) begin
          errors++;
          $display("FAIL reset_outputs got valid=%b data=%h sel=%0d exp valid=0 data=0 sel=0",
                   bus.out_valid, bus.out_data, bus.out_sel);
        end
      end
      q.delete();
      m_ptr = 0;
      m_occ = 0;
    end else if (m_occ == 0 || ordy) begin
      gi = pick(v, m_ptr);
      if (gi >= 0) begin
        exp_ready[gi[1:0]] = 1'b1;
        it.sel  = gi[1:0];
        it.data = dv[gi];
        q.push_back(it);
        pushed_now = 1;
        m_ptr = (gi + 1) % 4;
        m_occ = 1;
      end else begin
        m_occ = 0;
      end
    end
    m_prev_rst = r ? 1 : 0;
    checks++;
    if (bus.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready got %b exp %b (in_valid=%b rst=%b)", bus.in_ready, exp_ready, v, r);
    end
  endtask

  // Monitor: compares the held word with the scoreboard head; pops on consumption.
  initial begin
    int held;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        held = q.size() - pushed_now;
        checks++;
        if (bus.out_valid !== (held > 0)) begin
          errors++;
          $display("FAIL out_valid got %b exp %0d", bus.out_valid, held > 0);
        end else if (held > 0) begin
          checks++;
          if (bus.out_sel !== q[0].sel || bus.out_data !== q[0].data) begin
            errors++;
            $display("FAIL out_word got sel=%0d data=%h exp sel=%0d data=%h",
                     bus.out_sel, bus.out_data, q[0].sel, q[0].data);
          end
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb, rc, rd;
    logic [3:0]   rv;
    logic         rr, ro;
    errors = 0; checks = 0; pushed_now = 0;
    m_ptr = 0; m_occ = 0; m_prev_rst = 0;
    rst = 1'b1;
    bus.in_valid = '0; bus.out_ready = 1'b0;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;

    // Reset with all sources requesting.
    repeat (3) cycle(1'b1, 4'hF, 8'hA, 8'hB, 8'hC, 8'hD, 1'b1);
    // Full contention: grants 0,1,2,3,0.
    repeat (5) cycle(1'b0, 4'hF, 8'hA, 8'hB, 8'hC, 8'hD, 1'b1);
    // Sparse with wrap: grant 2, lone 1, then 1001 -> 3 then 0.
    cycle(1'b0, 4'b0100, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1);
    cycle(1'b0, 4'b0010, 8'h20, 8'h21, 8'h22, 8'h23, 1'b1);
    cycle(1'b0, 4'b1001, 8'h30, 8'h31, 8'h32, 8'h33, 1'b1);
    cycle(1'b0, 4'b1001, 8'h40, 8'h41, 8'h42, 8'h43, 1'b1);
    // Backpressure: hold 5 from source 2 for three stalled cycles, then grant 3.
    cycle(1'b0, 4'b0100, 8'h00, 8'h00, 8'h05, 8'h00, 1'b1);
    repeat (3) cycle(1'b0, 4'hF, 8'h50, 8'h51, 8'h52, 8'h53, 1'b0);
    cycle(1'b0, 4'hF, 8'h60, 8'h61, 8'h62, 8'h63, 1'b1);
    // Drain to empty after a single source-1 word.
    cycle(1'b0, 4'b0010, 8'h70, 8'h71, 8'h72, 8'h73, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    // Reset mid-stall, then first grant must be source 0.
    cycle(1'b0, 4'hF, 8'h80, 8'h81, 8'h82, 8'h83, 1'b0);
    cycle(1'b0, 4'hF, 8'h90, 8'h91, 8'h92, 8'h93, 1'b0);
    cycle(1'b1, 4'hF, 8'h90, 8'h91, 8'h92, 8'h93, 1'b0);
    repeat (3) cycle(1'b0, 4'hF, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
      rv = 4'($urandom);
      ro = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 49) == 0);
      cycle(rr, rv, ra, rb, rc, rd, ro);
    end
    cycle(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_4_stage.md
# rr_mux_4_stage

Registered 4-input round-robin arbitrating multiplexer stage. Four valid/ready sources present WIDTH-bit words. Each accepted cycle, the block grants one source in fair rotating order, selects its data through an and-or 4:1 mux, and holds the result in a one-entry output register with a valid/ready handshake. It sits directly upstream of a consumer that needs both a single data stream and the 2-bit source index of each word.

## Interface
- WIDTH, default 4: data word width; legal range ≥ 1.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- in_valid  input  4  per-source request; bit i qualifies d_i.
- in_ready  output  4  per-source accept; at most one bit high (one-hot or zero).
- d0, d1, d2, d3  input  WIDTH each  source data words.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  2  registered index of the source that produced out_data.

## Operation
- State: output register (out_valid, out_data, out_sel) and a 2-bit rotation pointer ptr.
- ptr is the highest-priority index.
- load_en = ~out_valid | out_ready: the slot is empty or drains this cycle.
- Grant search order is ptr, ptr+1, ptr+2, ptr+3, each mod 4. The grant g is the first index in that order with in_valid set.
- When load_en is high and any in_valid bit is set:
  - in_ready[g] = 1; all other in_ready bits are 0.
  - Next cycle: out_data = d_g, out_sel = g, out_valid = 1.
  - ptr <= g+1 mod 4, so g wraps 3 -> 0.
- When load_en is high and no in_valid bit is set:
  - in_ready = 0.
  - out_valid <= 0; out_data and out_sel hold their previous values.
  - ptr holds.
- When load_en is low (out_valid & ~out_ready, the stall case):
  - in_ready = 0.
  - Output register and ptr hold.
  - out_data and out_sel must stay stable while out_valid is high and unaccepted.
- A source keeping in_valid high after acceptance is a new request. It competes again at its rotated priority.
- Sources may drop in_valid without being granted. No request state is latched.
- Data selection uses and-or gating with decoded one-hot select terms; no behavioural ternary chains.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 in every cycle where rst is high, regardless of other inputs.
- Reset mid-transfer discards the held word. The first post-reset grant starts from index 0.
- Latency: a word accepted in cycle N appears on out_data with out_valid high in cycle N+1.
- Throughput: one word per cycle when out_ready is held high.
- in_ready is combinational from in_valid, out_valid, out_ready and ptr. It has no combinational path from any d_i.
- out_valid, out_data and out_sel are pure register outputs.
- Simultaneous drain and load (out_valid & out_ready & any in_valid) replaces the word in the same edge with no bubble.

## Structure
- Package rr_mux_pkg holds:
  - localparam N_SRC = 4;
  - typedef logic [1:0] src_idx_t for ptr, g and out_sel.
- Sub-module rr_pick_4 (combinational) takes inputs req[3:0] and ptr, and produces outputs any and g. It rotates req by ptr, applies a fixed-priority pick, and un-rotates the result.
- The top level holds load_en, the and-or data mux, the output register and the ptr register.

## Test plan
- Reset check: hold rst high with in_valid=4'hF and out_ready=1. Required: in_ready=0, out_valid=0, out_data=0, out_sel=0. After release, the first grant goes to source 0.
- Full contention: in_valid=4'hF, out_ready=1, with d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD.
  - Required out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data A,B,C,D,A.
  - in_ready one-hot in every cycle.
- Sparse with wrap: after grant 2, only in_valid[1] is high. Required: grant to 1 and ptr=2. Then in_valid=4'b1001 is granted 3 first, then 0.
- Backpressure: out_valid=1 holding 4'h5 from source 2, out_ready=0 for 3 cycles, in_valid=4'hF.
  - Required: in_ready=0 throughout; out_data=5 and out_sel=2 stable.
  - On the out_ready rise, source 3 is granted in the same cycle.
- Drain to empty: a single request from source 1 with out_ready=1 and no further requests. Required: out_valid high for exactly one cycle, then 0; ptr=2.
- Reset mid-stall: assert rst while out_valid=1 and out_ready=0. Required: out_valid=0 next cycle, and the first post-reset grant is source 0 even when all four sources request.
